// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side master for the synchronous FIFO. Issues fifo_rd_en whenever the
// FIFO has data and the 2-entry output buffer has room (counting the word
// already in flight), captures the one-cycle-latency fifo_data_out and
// re-presents it on a valid/ready stream at up to one word per cycle.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   enable           : permits new FIFO reads (IDLE <-> RUN)
//   clr_err          : synchronous clear of underflow_err (set has priority)
//   fifo_data_out    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty       : FIFO empty flag
//   fifo_underflow   : FIFO underflow flag
//   fifo_rd_en       : read request to the FIFO
//   m_data, m_valid  : stream output (head of the output buffer)
//   m_ready          : stream consumer ready
//   word_cnt         : handshakes completed since reset (wraps)
//   underflow_err    : sticky underflow indication
//   busy             : a read is in flight or the buffer holds data
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr_err,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  underflow_err,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              occ_q, occ_d;
  logic                    inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0]   buf0_q, buf0_d;   // head (oldest word)
  logic [FIFO_WIDTH-1:0]   buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
  logic                    err_q, err_d;

  logic                    pop_s;
  logic [2:0]              level_s;

  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf0_q;
  assign word_cnt      = word_cnt_q;
  assign underflow_err = err_q;
  assign busy          = m_valid | inflight_q;
  assign pop_s         = m_valid & m_ready;

  // Buffer level after this cycle's pop; pop implies occ >= 1, so no wrap.
  assign level_s    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign fifo_rd_en = (state_q == ST_RUN) & ~fifo_empty & (level_s < 3'd2);

  // Next-state logic for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output buffer update: capture in-flight data and/or shift on pop.
  // Capture does not depend on the FSM, so in-flight words are never lost.
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    case ({inflight_q, pop_s})
      2'b11: begin
        if (occ_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_out;
        end else begin
          buf0_d = fifo_data_out;
        end
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_data_out;
        end else begin
          buf1_d = fifo_data_out;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Delivered-word counter and sticky underflow flag (set beats clear).
  always_comb begin
    word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop_s};
    if (fifo_underflow) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= {FIFO_WIDTH{1'b0}};
      buf1_q     <= {FIFO_WIDTH{1'b0}};
      word_cnt_q <= {CNT_WIDTH{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule
